// File: rtl/generation_step_controller_if.sv
// Handshake bundle between the step controller, the button front end and the grid engine.
interface generation_step_controller_if;
    logic        run_toggle;
    logic        step_pulse;
    logic        clear_pulse;
    logic        step_ack;
    logic        step_req;
    logic        running;
    logic        busy;
    logic [15:0] generation;

    modport master (
        input  run_toggle, step_pulse, clear_pulse, step_ack,
        output step_req, running, busy, generation
    );

    modport slave (
        output run_toggle, step_pulse, clear_pulse, step_ack,
        input  step_req, running, busy, generation
    );
endinterface

// File: rtl/generation_step_controller.sv
// Paces generation steps: free-running ticks in run mode, single steps while paused,
// saturating generation counter with deferred clear while a request is outstanding.
module generation_step_controller #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned MAX_GEN  = 9999
) (
    input  logic                                clk,
    input  logic                                rst_n,
    generation_step_controller_if.master        bus
);
    localparam int unsigned   TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [15:0]   GEN_MAX   = 16'(MAX_GEN);

    typedef enum logic [1:0] {IDLE, WAIT_TICK, REQ} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [TW-1:0] r_tick;
    logic [TW-1:0] w_tick_d;
    logic [15:0]   r_gen;
    logic [15:0]   w_gen_d;
    logic          r_running;
    logic          w_running_d;
    logic          r_pend_clr;
    logic          w_pend_clr_d;
    logic          r_step_req;
    logic          r_busy;
    logic          w_req_d;
    logic          w_ack;

    assign w_ack       = (r_state == REQ) && bus.step_ack;
    // running is always 0 in IDLE, so a plain toggle covers start, stop and mid-request pause
    assign w_running_d = r_running ^ bus.run_toggle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_tick     <= '0;
            r_gen      <= '0;
            r_running  <= 1'b0;
            r_pend_clr <= 1'b0;
            r_step_req <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_tick     <= w_tick_d;
            r_gen      <= w_gen_d;
            r_running  <= w_running_d;
            r_pend_clr <= w_pend_clr_d;
            r_step_req <= w_req_d;
            r_busy     <= w_req_d;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.run_toggle)      w_next_state = WAIT_TICK;
                else if (bus.step_pulse) w_next_state = REQ;
            end
            WAIT_TICK: begin
                if (bus.run_toggle)           w_next_state = IDLE;
                else if (r_tick == TICK_LAST) w_next_state = REQ;
            end
            REQ: begin
                if (bus.step_ack) w_next_state = w_running_d ? WAIT_TICK : IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_req_d      = (w_next_state == REQ);
        w_tick_d     = ((r_state == WAIT_TICK) && (w_next_state == WAIT_TICK)) ? r_tick + TICK_ONE : '0;
        w_pend_clr_d = r_pend_clr;
        w_gen_d      = r_gen;
        if (w_ack) begin
            w_pend_clr_d = 1'b0;
            if (r_pend_clr || bus.clear_pulse) w_gen_d = '0;
            else if (r_gen < GEN_MAX)          w_gen_d = r_gen + 16'd1;
        end else if (bus.clear_pulse) begin
            // a clear during an outstanding request is applied when the ack lands
            if (r_state == REQ) w_pend_clr_d = 1'b1;
            else                w_gen_d      = '0;
        end
    end

    assign bus.step_req   = r_step_req;
    assign bus.busy       = r_busy;
    assign bus.running    = r_running;
    assign bus.generation = r_gen;
endmodule

// File: tb/tb_generation_step_controller.sv
// Scenario bench for generation_step_controller: expected generations are queued when
// the ack is driven and popped when the count is sampled.
module tb_generation_step_controller;
    logic        clk;
    logic        rst_n;
    int unsigned cyc = 0;
    int          checks = 0;
    int          passed = 0;
    int          mgen = 0;
    logic [15:0] sb_q[$];

    generation_step_controller_if bus();
    generation_step_controller_if sbus();

    generation_step_controller #(.TICK_DIV(4), .MAX_GEN(9999)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    generation_step_controller #(.TICK_DIV(4), .MAX_GEN(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int next_gen(input int g);
        return (g < 9999) ? g + 1 : g;
    endfunction

    task automatic pulse_run();
        @(negedge clk); bus.run_toggle = 1'b1;
        @(negedge clk); bus.run_toggle = 1'b0;
    endtask

    task automatic pulse_step();
        @(negedge clk); bus.step_pulse = 1'b1;
        @(negedge clk); bus.step_pulse = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk); bus.clear_pulse = 1'b1;
        @(negedge clk); bus.clear_pulse = 1'b0;
    endtask

    // Waits (bounded) for step_req, holds off the ack for 'delay' cycles, returns cycles seen high
    task automatic serve_req(input int delay, input bit clr_at_ack,
                             output int high, output int rise_cyc, output bit to);
        int w = 0;
        high = 0; rise_cyc = 0; to = 1'b0;
        while (bus.step_req !== 1'b1 && w < 40) begin @(negedge clk); w++; end
        if (bus.step_req !== 1'b1) begin to = 1'b1; return; end
        rise_cyc = int'(cyc);
        high = 1;
        repeat (delay) begin @(negedge clk); if (bus.step_req === 1'b1) high++; end
        bus.step_ack = 1'b1;
        if (clr_at_ack) bus.clear_pulse = 1'b1;
        @(negedge clk);
        bus.step_ack = 1'b0;
        bus.clear_pulse = 1'b0;
        if (bus.step_req === 1'b1) high++;
    endtask

    task automatic test_reset();
        checks++; if (bus.step_req !== 1'b0) $display("FAIL reset_step_req got %b want 0", bus.step_req); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
        checks++; if (bus.running !== 1'b0) $display("FAIL reset_running got %b want 0", bus.running); else passed++;
        checks++; if (bus.generation !== 16'd0) $display("FAIL reset_generation got %0d want 0", bus.generation); else passed++;
        checks++; if (sbus.generation !== 16'd0) $display("FAIL reset_sat_generation got %0d want 0", sbus.generation); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_paused_step();
        int high, rc, seen; bit to; logic [15:0] exp;
        pulse_step();
        checks++; if (bus.busy !== 1'b1) $display("FAIL paused_busy got %b want 1", bus.busy); else passed++;
        mgen = next_gen(mgen); sb_q.push_back(16'(mgen));
        serve_req(3, 1'b0, high, rc, to);
        exp = sb_q.pop_front();
        checks++; if (to || high != 4) $display("FAIL paused_req_cycles got %0d (timeout %b) want 4", high, to); else passed++;
        checks++; if (bus.generation !== exp) $display("FAIL paused_generation got %0d want %0d", bus.generation, exp); else passed++;
        checks++; if (bus.running !== 1'b0) $display("FAIL paused_running got %b want 0", bus.running); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL paused_busy_after got %b want 0", bus.busy); else passed++;
        seen = 0;
        repeat (8) begin @(negedge clk); if (bus.step_req === 1'b1) seen = 1; end
        checks++; if (seen != 0) $display("FAIL paused_back_idle got req=%0d want 0", seen); else passed++;
    endtask

    task automatic test_ignored_inputs();
        @(negedge clk); bus.step_ack = 1'b1;
        @(negedge clk); bus.step_ack = 1'b0;
        checks++; if (bus.generation !== 16'(mgen)) $display("FAIL stray_ack_generation got %0d want %0d", bus.generation, mgen); else passed++;
        checks++; if (bus.step_req !== 1'b0) $display("FAIL stray_ack_req got %b want 0", bus.step_req); else passed++;
        pulse_clear();
        mgen = 0;
        checks++; if (bus.generation !== 16'd0) $display("FAIL idle_clear got %0d want 0", bus.generation); else passed++;
    endtask

    task automatic test_run_mode();
        int high, rc, prev, seen; bit to; logic [15:0] exp;
        prev = 0;
        pulse_run();
        checks++; if (bus.running !== 1'b1) $display("FAIL run_running got %b want 1", bus.running); else passed++;
        for (int i = 0; i < 5; i++) begin
            mgen = next_gen(mgen); sb_q.push_back(16'(mgen));
            serve_req(1, 1'b0, high, rc, to);
            exp = sb_q.pop_front();
            if (to) begin checks++; $display("FAIL run_req_timeout got none want step_req (req %0d)", i); end
            checks++; if (bus.generation !== exp) $display("FAIL run_generation got %0d want %0d", bus.generation, exp); else passed++;
            if (i > 0) begin
                checks++; if (rc - prev != 6) $display("FAIL run_period got %0d want 6", rc - prev); else passed++;
            end
            prev = rc;
        end
        checks++; if (bus.generation !== 16'd5) $display("FAIL run_total got %0d want 5", bus.generation); else passed++;
        pulse_run();
        checks++; if (bus.running !== 1'b0) $display("FAIL run_stop got %b want 0", bus.running); else passed++;
        seen = 0;
        repeat (10) begin @(negedge clk); if (bus.step_req === 1'b1) seen = 1; end
        checks++; if (seen != 0) $display("FAIL run_stop_quiet got req=%0d want 0", seen); else passed++;
    endtask

    task automatic test_clear_during_req();
        int high, rc; bit to; logic [15:0] exp;
        while (mgen < 7) begin
            pulse_step();
            mgen = next_gen(mgen); sb_q.push_back(16'(mgen));
            serve_req(0, 1'b0, high, rc, to);
            exp = sb_q.pop_front();
            checks++; if (to || bus.generation !== exp) $display("FAIL prefill_generation got %0d want %0d", bus.generation, exp); else passed++;
        end
        pulse_step();
        bus.clear_pulse = 1'b1;
        @(negedge clk); bus.clear_pulse = 1'b0;
        checks++; if (bus.generation !== 16'd7) $display("FAIL clear_deferred got %0d want 7", bus.generation); else passed++;
        mgen = 0; sb_q.push_back(16'd0);
        serve_req(1, 1'b0, high, rc, to);
        exp = sb_q.pop_front();
        checks++; if (to || bus.generation !== exp) $display("FAIL clear_in_req got %0d want %0d", bus.generation, exp); else passed++;
        pulse_step();
        mgen = next_gen(mgen); sb_q.push_back(16'(mgen));
        serve_req(0, 1'b0, high, rc, to);
        exp = sb_q.pop_front();
        checks++; if (to || bus.generation !== exp) $display("FAIL step_after_clear got %0d want %0d", bus.generation, exp); else passed++;
        pulse_step();
        mgen = 0; sb_q.push_back(16'd0);
        serve_req(2, 1'b1, high, rc, to);
        exp = sb_q.pop_front();
        checks++; if (to || bus.generation !== exp) $display("FAIL clear_with_ack got %0d want %0d", bus.generation, exp); else passed++;
    endtask

    task automatic test_pause_during_req();
        int high, rc, w, seen; bit to; logic [15:0] exp;
        pulse_run();
        w = 0;
        while (bus.step_req !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        checks++; if (bus.busy !== 1'b1) $display("FAIL pause_req_busy got %b want 1", bus.busy); else passed++;
        bus.run_toggle = 1'b1;
        @(negedge clk); bus.run_toggle = 1'b0;
        checks++; if (bus.running !== 1'b0) $display("FAIL pause_running got %b want 0", bus.running); else passed++;
        checks++; if (bus.step_req !== 1'b1) $display("FAIL pause_req_held got %b want 1", bus.step_req); else passed++;
        mgen = next_gen(mgen); sb_q.push_back(16'(mgen));
        serve_req(1, 1'b0, high, rc, to);
        exp = sb_q.pop_front();
        checks++; if (to || bus.generation !== exp) $display("FAIL pause_generation got %0d want %0d", bus.generation, exp); else passed++;
        seen = 0;
        repeat (12) begin @(negedge clk); if (bus.step_req === 1'b1) seen = 1; end
        checks++; if (seen != 0 || bus.running !== 1'b0) $display("FAIL pause_idle got req=%0d running=%b want 0/0", seen, bus.running); else passed++;
    endtask

    task automatic test_saturation();
        int sgen, w; logic [15:0] exp;
        sgen = 0;
        for (int i = 0; i < 4; i++) begin
            sgen = (sgen < 3) ? sgen + 1 : 3;
            sb_q.push_back(16'(sgen));
            @(negedge clk); sbus.step_pulse = 1'b1;
            @(negedge clk); sbus.step_pulse = 1'b0;
            w = 0;
            while (sbus.step_req !== 1'b1 && w < 20) begin @(negedge clk); w++; end
            if (sbus.step_req !== 1'b1) begin checks++; $display("FAIL sat_req_timeout got none want step_req"); end
            sbus.step_ack = 1'b1;
            @(negedge clk); sbus.step_ack = 1'b0;
            exp = sb_q.pop_front();
            checks++; if (sbus.generation !== exp) $display("FAIL sat_generation got %0d want %0d", sbus.generation, exp); else passed++;
        end
    endtask

    task automatic test_async_reset();
        int high, rc; bit to; logic [15:0] exp;
        while (mgen < 42) begin
            pulse_step();
            mgen = next_gen(mgen); sb_q.push_back(16'(mgen));
            serve_req(0, 1'b0, high, rc, to);
            exp = sb_q.pop_front();
            if (to) begin checks++; $display("FAIL fill42_timeout got none want step_req"); end
        end
        checks++; if (bus.generation !== 16'd42) $display("FAIL fill42 got %0d want 42", bus.generation); else passed++;
        pulse_step();
        checks++; if (bus.step_req !== 1'b1) $display("FAIL pre_reset_req got %b want 1", bus.step_req); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.step_req !== 1'b0) $display("FAIL async_step_req got %b want 0", bus.step_req); else passed++;
        checks++; if (bus.generation !== 16'd0) $display("FAIL async_generation got %0d want 0", bus.generation); else passed++;
        checks++; if (bus.running !== 1'b0 || bus.busy !== 1'b0) $display("FAIL async_running_busy got %b/%b want 0/0", bus.running, bus.busy); else passed++;
        @(negedge clk); rst_n = 1'b1;
        mgen = 0;
        pulse_step();
        mgen = next_gen(mgen); sb_q.push_back(16'(mgen));
        serve_req(0, 1'b0, high, rc, to);
        exp = sb_q.pop_front();
        checks++; if (to || bus.generation !== exp) $display("FAIL post_reset_step got %0d want %0d", bus.generation, exp); else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.run_toggle = 1'b0; bus.step_pulse = 1'b0; bus.clear_pulse = 1'b0; bus.step_ack = 1'b0;
        sbus.run_toggle = 1'b0; sbus.step_pulse = 1'b0; sbus.clear_pulse = 1'b0; sbus.step_ack = 1'b0;
        #2;
        test_reset();
        test_paused_step();
        test_ignored_inputs();
        test_run_mode();
        test_clear_during_req();
        test_pause_during_req();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/generation_step_controller.md
GENERATION_STEP_CONTROLLER -- requirements
Module: generation_step_controller

Interface
REQ-001 Parameter TICK_DIV, default 50000000: number of clk cycles between automatic step requests in run mode; legal range is 2 or more.
REQ-002 Parameter MAX_GEN, default 9999: saturation value of the generation count, matching the four-digit decimal display.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 run_toggle  input  1  single-cycle, already-debounced pulse; toggles run/pause.
REQ-006 step_pulse  input  1  single-cycle, already-debounced pulse; requests one generation while paused.
REQ-007 clear_pulse  input  1  single-cycle, already-debounced pulse; zeroes the generation count.
REQ-008 step_req  output  1  request to the grid engine to compute the next generation.
REQ-009 step_ack  input  1  single-cycle pulse from the grid engine: generation computed.
REQ-010 generation  output  16  unsigned binary generation count; feeds the seven-segment display stage.
REQ-011 running  output  1  1 = run mode, 0 = paused.
REQ-012 busy  output  1  1 while a step request is outstanding (state REQ).

Function
REQ-013 FSM states: IDLE, WAIT_TICK, REQ.
REQ-014 IDLE: if run_toggle=1, set running=1, clear the tick counter, and go to WAIT_TICK; otherwise, if step_pulse=1, go to REQ.
REQ-015 WAIT_TICK: increment the tick counter each cycle.
- When tick counter = TICK_DIV-1: clear it and go to REQ.
- run_toggle=1 has priority: set running=0, clear the tick counter, go to IDLE.
REQ-016 REQ: step_req=1, busy=1; step_req holds high until step_ack is sampled 1 (no timeout).
REQ-017 On step_ack=1 in REQ, step_req drops on the next edge.
- Next state is WAIT_TICK if running=1 (tick counter starts from 0), else IDLE.
REQ-018 run_toggle in REQ toggles running immediately; the outstanding request still completes, and the post-ack state follows the updated running value.
REQ-019 step_pulse is ignored in WAIT_TICK and REQ.
REQ-020 step_ack outside REQ is ignored and does not change generation.
REQ-021 generation increments by 1 on the same edge that REQ accepts step_ack, and saturates at MAX_GEN.
REQ-022 generation never exceeds MAX_GEN and never wraps.
REQ-023 clear_pulse in IDLE or WAIT_TICK zeroes generation on the next edge; FSM state and tick counter are unaffected.
REQ-024 clear_pulse in REQ sets a pending-clear flag; on ack, generation becomes 0 (not incremented) and the flag clears.
REQ-025 If clear_pulse and step_ack coincide in REQ, generation becomes 0.
REQ-026 Tick counter width is clog2(TICK_DIV) bits; the counter never exceeds TICK_DIV-1.
REQ-027 Outputs step_req, busy and running are registered (no combinational path from inputs).

Reset
REQ-028 While rst_n=0, asynchronously:
- state=IDLE, step_req=0, busy=0, running=0;
- generation=0, tick counter=0, pending-clear=0.
REQ-029 Reset asserted mid-request drops step_req immediately; no generation increment occurs.
REQ-030 After rst_n deasserts, the first active edge behaves as IDLE.

Verification (TICK_DIV=4, MAX_GEN=9999 unless noted)
REQ-031 Paused step: step_pulse, ack after 3 cycles -> step_req high exactly 4 cycles, generation 0->1, running=0, back in IDLE.
REQ-032 Run mode: run_toggle, ack returned 1 cycle after each request -> step_req rises every 4+2 cycles; generation reaches 5 after 5 requests.
REQ-033 Saturation: MAX_GEN=3, four paused steps -> generation sequence 1,2,3,3.
REQ-034 Clear during REQ: generation=7, step, clear_pulse before ack -> generation=0 after ack, not 8.
REQ-035 Pause during REQ: run_toggle while step_req=1 -> running=0 at once; after ack generation +1, state IDLE, no further step_req.
REQ-036 Async reset with step_req=1 and generation=42 -> step_req=0, generation=0, running=0 without a clock edge.
